// File: rtl/riscv_pkg.sv
// Shared core constants and the divider writeback entry type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 6;

    // One buffered divider result waiting for the CDB.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } div_wb_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with occupancy count and a synchronous clear.
// Latency: a push is visible at head the cycle after the write edge; no bypass.
// Backpressure: push ignored when full, pop ignored when empty; clear wins over both.
// Ports: clk/rst (sync, active-high), clear, push/push_data, pop, head, count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths stay inside the array.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/div_writeback_buffer.sv
// Pairs fixed-latency divider results with their ROB tags and buffers them for the CDB.
// Latency: div_valid to cdb_valid is 1 cycle with an empty buffer (registered, no bypass).
// Backpressure: credit based; issue_ready counts in-flight plus buffered ops against DEPTH,
//   so the divider never produces a result the buffer cannot take. cdb_ready only pops.
// Ports: issue_* from the scheduler, div_* from the divider, cdb_* to the CDB arbiter,
//   flush squashes everything, err_orphan is a sticky tag/result pairing error.
module div_writeback_buffer #(
    parameter int XLEN        = riscv_pkg::XLEN,
    parameter int DIV_LATENCY = 6,
    parameter int TAG_W       = riscv_pkg::TAG_W,
    parameter int DEPTH       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             issue_ready,
    input  logic             div_valid,
    input  logic [XLEN-1:0]  div_result,
    input  logic             flush,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_data,
    input  logic             cdb_ready,
    output logic             err_orphan
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    // Same layout as riscv_pkg::div_wb_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } entry_t;

    typedef struct packed {
        logic             valid;
        logic             killed;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t           pipe [DIV_LATENCY];
    stage_t           out_stage;
    logic [CNT_W-1:0] inflight_cnt;
    logic [CNT_W-1:0] fifo_cnt;
    logic             issue_acc;
    logic             push;
    logic             pop;
    entry_t           push_entry;
    entry_t           head_entry;

    assign out_stage = pipe[DIV_LATENCY-1];

    // Registered counts only: no path from cdb_ready to issue_ready.
    assign issue_ready = ({1'b0, inflight_cnt} + {1'b0, fifo_cnt}) < (CNT_W + 1)'(DEPTH);
    assign issue_acc   = issue_valid && issue_ready && !flush;

    // Flush clears the FIFO this edge, so a result arriving in the flush cycle is dropped too.
    assign push       = div_valid && out_stage.valid && !out_stage.killed && !flush;
    assign pop        = cdb_valid && cdb_ready;
    assign push_entry = '{tag: out_stage.tag, data: div_result};

    // Tag pipe: stage k holds the op issued k+1 cycles ago. Killed bits are set on
    // the shifted copy so the op moving between stages in the flush cycle is caught.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIV_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0].valid  <= issue_acc;
            pipe[0].killed <= 1'b0;
            pipe[0].tag    <= issue_tag;
            for (int i = 1; i < DIV_LATENCY; i++) begin
                pipe[i].valid  <= pipe[i-1].valid;
                pipe[i].killed <= pipe[i-1].killed | (flush & pipe[i-1].valid);
                pipe[i].tag    <= pipe[i-1].tag;
            end
        end
    end

    // An op leaves the in-flight count when its tag exits the pipe, killed or not,
    // so flushed credits come back only as the divider drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_cnt <= '0;
        end else if (issue_acc && !out_stage.valid) begin
            inflight_cnt <= inflight_cnt + 1'b1;
        end else if (!issue_acc && out_stage.valid) begin
            inflight_cnt <= inflight_cnt - 1'b1;
        end
    end

    // Any disagreement between divider valid and the tag pipe is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_orphan <= 1'b0;
        end else if (div_valid != out_stage.valid) begin
            err_orphan <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .count     (fifo_cnt)
    );

    // Head storage is not reset; force zeros whenever nothing is offered.
    assign cdb_valid = (fifo_cnt != '0);
    assign cdb_tag   = cdb_valid ? head_entry.tag  : '0;
    assign cdb_data  = cdb_valid ? head_entry.data : '0;

endmodule

// File: tb/tb_div_writeback_buffer.sv
// Directed bench for div_writeback_buffer with a behavioural fixed-latency divider.
// Latency: divider model returns issue_res exactly L cycles after issue_valid.
// Backpressure: cdb_ready driven per scenario; issue only while issue_ready.
module tb_div_writeback_buffer;
    import riscv_pkg::*;

    localparam int L = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic [TAG_W-1:0] issue_tag;
    logic             issue_ready;
    logic             div_valid;
    logic [XLEN-1:0]  div_result;
    logic             flush;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_data;
    logic             cdb_ready;
    logic             err_orphan;

    logic [XLEN-1:0]  issue_res;
    logic             inj_div;
    logic             div_mute;
    logic [L-1:0]     dv_pipe;
    logic [XLEN-1:0]  dr_pipe [L];

    int n_chk  = 0;
    int n_fail = 0;

    div_writeback_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_tag   (issue_tag),
        .issue_ready (issue_ready),
        .div_valid   (div_valid),
        .div_result  (div_result),
        .flush       (flush),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .cdb_ready   (cdb_ready),
        .err_orphan  (err_orphan)
    );

    always #5 clk = ~clk;

    // Divider model: valid_in is issue_valid, result appears L cycles later.
    always @(posedge clk) begin
        if (rst) begin
            dv_pipe <= '0;
        end else begin
            dv_pipe    <= {dv_pipe[L-2:0], issue_valid};
            dr_pipe[0] <= issue_res;
            for (int i = 1; i < L; i++) dr_pipe[i] <= dr_pipe[i-1];
        end
    end
    assign div_valid  = (dv_pipe[L-1] & ~div_mute) | inj_div;
    assign div_result = inj_div ? 32'hDEAD_BEEF : dr_pipe[L-1];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Issuing while not ready is an upstream violation this bench must never commit.
    always @(negedge clk) begin
        if (!rst && issue_valid) chk("issue_proto", issue_ready, 1);
    end

    // Inputs change and outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] res);
        issue_valid = 1'b1;
        issue_tag   = tag;
        issue_res   = res;
        tick();
        issue_valid = 1'b0;
    endtask

    div_wb_entry_t exp_q [4];

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_tag = '0; issue_res = '0;
        flush = 1'b0; cdb_ready = 1'b0; inj_div = 1'b0; div_mute = 1'b0;
        ticks(2);

        // Reset state
        chk("rst_cdb_valid", cdb_valid, 0);
        chk("rst_cdb_tag", cdb_tag, 0);
        chk("rst_cdb_data", cdb_data, 0);
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_err", err_orphan, 0);
        rst = 1'b0;
        tick();

        // Single op: tag 5 issued at t, result 0x7 at t+6, on CDB at t+7 for one cycle
        cdb_ready = 1'b1;
        issue(6'd5, 32'h7);                 // now t+1
        chk("s1_ready_t1", issue_ready, 1);
        ticks(5);                           // t+6
        chk("s1_no_bypass", cdb_valid, 0);
        tick();                             // t+7
        chk("s1_valid", cdb_valid, 1);
        chk("s1_tag", cdb_tag, 5);
        chk("s1_data", cdb_data, 32'h7);
        tick();                             // t+8
        chk("s1_one_cycle", cdb_valid, 0);

        // Fill: tags 1..4 back to back with the CDB stalled
        cdb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q[i].tag  = TAG_W'(i + 1);
            exp_q[i].data = 32'h100 + i + 1;
        end
        issue(exp_q[0].tag, exp_q[0].data);
        issue(exp_q[1].tag, exp_q[1].data);
        issue(exp_q[2].tag, exp_q[2].data);
        chk("s2_ready_after3", issue_ready, 1);
        issue(exp_q[3].tag, exp_q[3].data); // s+4
        chk("s2_ready_after4", issue_ready, 0);
        ticks(6);                           // s+10: all four buffered
        chk("s2_fifo_full", dut.fifo_cnt, 4);
        chk("s2_ready_full", issue_ready, 0);
        chk("s2_head_tag", cdb_tag, 1);
        tick();
        chk("s2_stall_tag", cdb_tag, 1);
        chk("s2_stall_data", cdb_data, 32'h101);

        // Drain: one pop per cycle, credit back the cycle after the first pop
        cdb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("s3_valid", cdb_valid, 1);
            chk("s3_tag", cdb_tag, exp_q[i].tag);
            chk("s3_data", cdb_data, exp_q[i].data);
            tick();
            if (i == 0) chk("s3_ready_after_pop", issue_ready, 1);
        end
        chk("s3_empty", cdb_valid, 0);

        // Simultaneous push and pop with one entry buffered
        cdb_ready = 1'b0;
        issue(6'd20, 32'h2000);
        issue(6'd21, 32'h2100);
        issue(6'd22, 32'h2200);             // c+3
        ticks(4);                           // c+7
        chk("s4_head20", cdb_tag, 20);
        chk("s4_cnt1", dut.fifo_cnt, 1);
        cdb_ready = 1'b1;
        tick();                             // c+8
        chk("s4_cnt_hold_a", dut.fifo_cnt, 1);
        chk("s4_head21", cdb_tag, 21);
        chk("s4_data21", cdb_data, 32'h2100);
        tick();                             // c+9
        chk("s4_cnt_hold_b", dut.fifo_cnt, 1);
        chk("s4_head22", cdb_tag, 22);
        tick();
        chk("s4_empty", cdb_valid, 0);

        // Flush with tags 10, 11 in flight: nothing reaches the CDB, credits drain
        issue(6'd10, 32'hA);                // t+1
        issue(6'd11, 32'hB);                // t+2
        tick();                             // t+3
        flush = 1'b1;
        tick();                             // t+4
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("s5_no_cdb", cdb_valid, 0);
            tick();
        end                                 // t+7
        chk("s5_inflight_t7", dut.inflight_cnt, 1);
        chk("s5_no_cdb_t7", cdb_valid, 0);
        tick();                             // after the t+7 edge
        chk("s5_inflight_0", dut.inflight_cnt, 0);
        chk("s5_no_cdb_t8", cdb_valid, 0);
        chk("s5_ready", issue_ready, 1);
        chk("s5_no_err", err_orphan, 0);

        // Flush with a buffered head, popped in the same cycle
        cdb_ready = 1'b0;
        issue(6'd30, 32'h30);
        ticks(6);
        chk("s6_head30", cdb_tag, 30);
        flush = 1'b1;
        cdb_ready = 1'b1;
        tick();
        flush = 1'b0;
        chk("s6_flushed_valid", cdb_valid, 0);
        chk("s6_flushed_cnt", dut.fifo_cnt, 0);
        chk("s6_ready", issue_ready, 1);

        // Orphan divider result
        inj_div = 1'b1;
        tick();
        inj_div = 1'b0;
        chk("s7_err_set", err_orphan, 1);
        chk("s7_no_cdb", cdb_valid, 0);
        ticks(3);
        chk("s7_err_sticky", err_orphan, 1);
        chk("s7_no_push", dut.fifo_cnt, 0);

        // Reset with two ops in flight and one buffered
        cdb_ready = 1'b0;
        issue(6'd40, 32'h40);               // r+1
        ticks(4);                           // r+5
        issue(6'd41, 32'h41);               // r+6
        issue(6'd42, 32'h42);               // r+7
        chk("s8_pre_buf", dut.fifo_cnt, 1);
        chk("s8_pre_inflight", dut.inflight_cnt, 2);
        rst = 1'b1;
        tick();
        chk("s8_cnt", dut.fifo_cnt, 0);
        chk("s8_inflight", dut.inflight_cnt, 0);
        chk("s8_valid", cdb_valid, 0);
        chk("s8_ready", issue_ready, 1);
        chk("s8_err", err_orphan, 0);
        rst = 1'b0;
        ticks(8);
        chk("s8_quiet_err", err_orphan, 0);
        chk("s8_quiet_cdb", cdb_valid, 0);

        // Tag pipe exits with no divider result: error, entry discarded
        div_mute = 1'b1;
        issue(6'd50, 32'h50);
        ticks(6);
        chk("s9_err", err_orphan, 1);
        chk("s9_no_cdb", cdb_valid, 0);
        chk("s9_inflight", dut.inflight_cnt, 0);
        div_mute = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_writeback_buffer.md
DIV_WRITEBACK_BUFFER -- requirements
Module: div_writeback_buffer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the data width.
REQ-002 The block SHALL have parameter DIV_LATENCY, default 6, meaning the divider valid_in-to-valid_out latency in cycles.
REQ-003 The block SHALL have parameter TAG_W, default 6, meaning the ROB tag width.
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning the result FIFO depth, which is also the credit limit.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port issue_valid, input, 1 bit: an op is issued this cycle; the same signal drives the divider valid_in.
REQ-008 The block SHALL have port issue_tag, input, TAG_W bits: the ROB tag of the issued op.
REQ-009 The block SHALL have port issue_ready, output, 1 bit: a credit is available, so issue is permitted.
REQ-010 The block SHALL have port div_valid, input, 1 bit: the divider valid_out.
REQ-011 The block SHALL have port div_result, input, XLEN bits: the divider quotient port, which already carries the remainder for REM/REMU.
REQ-012 The block SHALL have port flush, input, 1 bit: squash all in-flight and buffered ops.
REQ-013 The block SHALL have port cdb_valid, output, 1 bit: a result is offered to the CDB.
REQ-014 The block SHALL have port cdb_tag, output, TAG_W bits: the tag of the offered result.
REQ-015 The block SHALL have port cdb_data, output, XLEN bits: the offered result.
REQ-016 The block SHALL have port cdb_ready, input, 1 bit: the CDB arbiter accepts the result.
REQ-017 The block SHALL have port err_orphan, output, 1 bit: sticky error flag, set when div_valid arrives with no matching tracked op.

Function
REQ-018 The block SHALL hold a DIV_LATENCY-stage tag pipe of {valid, killed, tag}; when issue_valid && issue_ready, stage 0 SHALL load {1,0,issue_tag} at the next edge, and every stage SHALL shift each cycle.
REQ-019 The tag-pipe output stage SHALL align with div_valid, so an op issued at cycle t is paired with div_valid at cycle t+DIV_LATENCY.
REQ-020 The block SHALL keep inflight_cnt (0..DEPTH): +1 on an accepted issue, -1 when the tag-pipe output stage is valid, net 0 when both occur in the same cycle.
REQ-021 issue_ready SHALL equal (inflight_cnt + fifo_cnt) < DEPTH, registered-count based with no combinational path from cdb_ready; with this credit scheme a push never meets a full FIFO.
REQ-022 issue_valid while !issue_ready SHALL be ignored by the block (an upstream protocol violation); the bench asserts this never occurs.
REQ-023 When div_valid and the output stage is valid and not killed, {tag, div_result} SHALL be pushed into the FIFO.
REQ-024 When the output stage is valid and killed, the result SHALL be dropped with no push, and inflight_cnt SHALL still decrement.
REQ-025 When div_valid and the output stage is not valid, err_orphan SHALL set and hold until rst, and nothing SHALL be pushed.
REQ-026 When the output stage is valid and div_valid is low, err_orphan SHALL set and the entry SHALL be discarded.
REQ-027 cdb_valid/cdb_tag/cdb_data SHALL present the FIFO head; a pop SHALL occur when cdb_valid && cdb_ready; the outputs SHALL be stable while cdb_valid && !cdb_ready.
REQ-028 The latency from div_valid to cdb_valid SHALL be 1 cycle when the FIFO is empty, with no combinational bypass.
REQ-029 Simultaneous push and pop SHALL leave fifo_cnt unchanged, including when fifo_cnt==DEPTH-1 or fifo_cnt==1.
REQ-030 The FIFO pointers SHALL wrap modulo DEPTH.
REQ-031 On flush, the FIFO SHALL empty at the next edge, cdb_valid SHALL be 0 that next cycle, and all valid tag-pipe stages, including the one being shifted in that cycle, SHALL be marked killed.
REQ-032 On flush, issue_valid in the flush cycle SHALL be ignored, and inflight_cnt SHALL be preserved so credits return only as the killed ops drain.
REQ-033 A pop coinciding with flush SHALL still count as a CDB acceptance of the current head.

Reset
REQ-034 When rst is high at a clock edge, the tag pipe SHALL be cleared to invalid, inflight_cnt, fifo_cnt and the pointers SHALL be set to 0, and err_orphan SHALL be set to 0.
REQ-035 After reset, cdb_valid SHALL be 0, cdb_tag and cdb_data SHALL be 0, and issue_ready SHALL be 1.
REQ-036 rst mid-operation SHALL abandon all ops without an error flag; the divider shares rst, so no late div_valid follows.

Structure
REQ-037 Shared package riscv_pkg SHALL hold the XLEN and TAG_W constants and the typedef div_wb_entry_t {tag, data}.
REQ-038 One sub-module, sync_fifo (parameterised width and depth, count output), SHALL implement the result FIFO; the tag pipe and credit logic SHALL be local.

Verification
REQ-039 Scenario: single op with tag 5, divider result 0x7 at t+6, cdb_ready=1 -> cdb_valid=1 at t+7 with cdb_tag=5, cdb_data=0x7, for one cycle.
REQ-040 Scenario: back-to-back issue of tags 1..4 with cdb_ready=0 -> issue_ready=0 after the 4th issue, and the FIFO holds 1,2,3,4 in order.
REQ-041 Scenario: then raise cdb_ready -> one pop per cycle, and issue_ready=1 the cycle after the first pop.
REQ-042 Scenario: issue tags 10 and 11, flush at t+3 -> no cdb_valid ever; inflight_cnt drains to 0 at t+7, and issue_ready returns.
REQ-043 Scenario: div_valid pulse with no issued op -> err_orphan=1 and stays high; cdb_valid stays 0.
REQ-044 Scenario: rst asserted with 2 ops in flight and 1 buffered -> next cycle all counts are 0, cdb_valid=0, issue_ready=1, err_orphan=0.
